// File: rtl/v_dividers_seq_unsigned_if.sv
// ----------------------------------------------------------------------------
// v_dividers_seq_unsigned_if
//   Handshake and data bundle for the sequential unsigned divider.
//   master : requester side, drives start/A/B and observes the result.
//   slave  : divider side, samples start/A/B and drives busy/done/Q/R/DIVZ.
// Signals
//   start        request, accepted when the divider is idle or done
//   A   [WA-1:0] dividend
//   B   [WB-1:0] divisor
//   busy         high while iterating
//   done         one-cycle pulse when Q/R/DIVZ are updated
//   Q   [WA-1:0] quotient
//   R   [WB-1:0] remainder
//   DIVZ         current result came from a zero divisor
// ----------------------------------------------------------------------------
interface v_dividers_seq_unsigned_if #(
    parameter int WIDTHA = 32,
    parameter int WIDTHB = 24
);
    logic              start;
    logic [WIDTHA-1:0] A;
    logic [WIDTHB-1:0] B;
    logic              busy;
    logic              done;
    logic [WIDTHA-1:0] Q;
    logic [WIDTHB-1:0] R;
    logic              DIVZ;

    modport master (output start, A, B, input busy, done, Q, R, DIVZ);
    modport slave  (input start, A, B, output busy, done, Q, R, DIVZ);
endinterface

// File: rtl/v_dividers_seq_unsigned.sv
// ----------------------------------------------------------------------------
// v_dividers_seq_unsigned
//   Unsigned WIDTHA/WIDTHB restoring radix-2 divider, one quotient bit per
//   clock. Latency from the accepting edge to done is always WIDTHA cycles,
//   including the divide-by-zero case (which yields Q=all ones, R=A low bits).
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave modport: start/A/B in, busy/done/Q/R/DIVZ out
// ----------------------------------------------------------------------------
module v_dividers_seq_unsigned #(
    parameter int WIDTHA = 32,
    parameter int WIDTHB = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    v_dividers_seq_unsigned_if.slave     bus
);

    localparam int CW = $clog2(WIDTHA + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTHA-1:0] r_a;          // dividend shifting out, quotient shifting in
    logic [WIDTHB-1:0] r_b;
    // The partial remainder is always below the divisor between iterations,
    // so its upper bit is never set and only WIDTHB bits are stored.
    logic [WIDTHB-1:0] r_p;
    logic [CW-1:0]     r_cnt;
    logic              r_divz_next;
    logic              r_busy;
    logic              r_done;
    logic [WIDTHA-1:0] r_q;
    logic [WIDTHB-1:0] r_r;
    logic              r_divz;

    logic [WIDTHB:0]   w_t;
    logic              w_ge;
    logic [WIDTHB-1:0] w_p_next;
    logic [WIDTHA-1:0] w_a_next;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        w_t = {r_p, r_a[WIDTHA-1]};
        w_ge = (w_t >= {1'b0, r_b});
        if (w_ge) begin
            // True difference is below 2^WIDTHB, so the truncated subtract is exact.
            w_p_next = w_t[WIDTHB-1:0] - r_b;
        end else begin
            w_p_next = w_t[WIDTHB-1:0];
        end
        w_a_next = {r_a[WIDTHA-2:0], w_ge};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_divz_next <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_divz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_a         <= bus.A;
                        r_b         <= bus.B;
                        r_p         <= '0;
                        r_cnt       <= CW'(WIDTHA);
                        r_divz_next <= (bus.B == '0);
                        r_busy      <= 1'b1;
                        r_state     <= ST_CALC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_a   <= w_a_next;
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt - CW'(1);
                    // Last iteration: publish the freshly completed quotient bit too.
                    if (r_cnt == CW'(1)) begin
                        r_q     <= w_a_next;
                        r_r     <= w_p_next;
                        r_divz  <= r_divz_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.Q    = r_q;
    assign bus.R    = r_r;
    assign bus.DIVZ = r_divz;

endmodule
